// File: rtl/character_jump.sv
// character_jump
// Player-character stage of the VGA pipeline. It draws a solid CHAR_W x CHAR_H
// rectangle of CHAR_COLOR over the incoming pixel stream and owns the
// character position. On each frame tick (the rising edge of vsync) it applies
// the horizontal step and advances the jump/gravity state machine.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   module_en    drawing and physics enable
//   jump         jump request (level or pulse)
//   move_left    step left at the next frame tick
//   move_right   step right at the next frame tick
//   vga_bus_in   {hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk, rgb[11:0]}
//   vga_bus_out  same fields, one register stage later
//   pos_x/pos_y  current left / top edge
//   airborne     high in RISE or FALL
//   landed       one-cycle pulse on touchdown
//
// state | meaning
// IDLE  | on the ground, waiting for a jump request
// RISE  | moving up, speed decaying under gravity
// FALL  | moving down, speed growing up to VMAX
module character_jump #(
  parameter int          CHAR_W       = 32,
  parameter int          CHAR_H       = 48,
  parameter logic [11:0] CHAR_COLOR   = 12'h000,
  parameter int          SCREEN_W     = 800,
  parameter int          X_INIT       = 384,
  parameter int          GROUND_Y     = 400,
  parameter int          JUMP_V       = 16,
  parameter int          GRAVITY      = 1,
  parameter int          VMAX         = 16,
  parameter int          X_STEP       = 4,
  parameter int          VGA_BUS_SIZE = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    module_en,
  input  logic                    jump,
  input  logic                    move_left,
  input  logic                    move_right,
  input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic [10:0]             pos_x,
  output logic [10:0]             pos_y,
  output logic                    airborne,
  output logic                    landed
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RISE = 2'd1;
  localparam logic [1:0] FALL = 2'd2;

  localparam logic [11:0] X_MAX = 12'(SCREEN_W - CHAR_W);

  logic [10:0] hcount, vcount;
  logic        hblnk, vsync, vblnk;
  logic [11:0] rgb_in;

  assign hcount = vga_bus_in[37:27];
  assign hblnk  = vga_bus_in[25];
  assign vcount = vga_bus_in[24:14];
  assign vsync  = vga_bus_in[13];
  assign vblnk  = vga_bus_in[12];
  assign rgb_in = vga_bus_in[11:0];

  logic [1:0]        state;
  logic [10:0]       x, y;
  logic signed [7:0] vel;
  logic              jump_pend, vsync_d;

  logic              tick, step;
  logic signed [11:0] ny;
  logic signed [7:0]  vel_g;
  logic [11:0]        x_right;
  logic [11:0]        x_end, y_end;
  logic               in_box;
  logic [11:0]        rgb_nxt;

  assign tick  = vsync & ~vsync_d;
  assign step  = tick & module_en;
  assign ny    = $signed({1'b0, y}) + $signed({{4{vel[7]}}, vel});
  assign vel_g = vel + $signed(8'(GRAVITY));

  assign x_right = {1'b0, x} + 12'(X_STEP);

  assign x_end  = {1'b0, x} + 12'(CHAR_W - 1);
  assign y_end  = {1'b0, y} + 12'(CHAR_H - 1);
  assign in_box = module_en && !hblnk && !vblnk &&
                  (hcount >= x) && ({1'b0, hcount} <= x_end) &&
                  (vcount >= y) && ({1'b0, vcount} <= y_end);
  assign rgb_nxt = in_box ? CHAR_COLOR : rgb_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_bus_out <= '0;
      vsync_d     <= 1'b0;
      jump_pend   <= 1'b0;
    end else begin
      vga_bus_out <= {vga_bus_in[VGA_BUS_SIZE-1:12], rgb_nxt};
      vsync_d     <= vsync;
      // The tick always consumes the request, accepted or not, so jumps
      // never carry across a landing.
      jump_pend   <= tick ? 1'b0 : (jump_pend | jump);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x      <= 11'(X_INIT);
      y      <= 11'(GROUND_Y);
      vel    <= '0;
      landed <= 1'b0;
    end else begin
      landed <= 1'b0;
      if (step) begin
        case (state)
          IDLE: begin
            if (jump_pend | jump) begin
              vel   <= -8'(JUMP_V);
              state <= RISE;
            end else begin
              y   <= 11'(GROUND_Y);
              vel <= '0;
            end
          end
          RISE: begin
            if (ny < 0) begin
              y     <= '0;
              vel   <= '0;
              state <= FALL;
            end else begin
              y   <= ny[10:0];
              vel <= vel_g;
              if (!vel_g[7]) state <= FALL;
            end
          end
          FALL: begin
            if (ny >= $signed(12'(GROUND_Y))) begin
              y      <= 11'(GROUND_Y);
              vel    <= '0;
              state  <= IDLE;
              landed <= 1'b1;
            end else begin
              y   <= ny[10:0];
              vel <= (vel_g > $signed(8'(VMAX))) ? 8'(VMAX) : vel_g;
            end
          end
          default: state <= IDLE;
        endcase

        if (move_left && !move_right)
          x <= (x < 11'(X_STEP)) ? 11'd0 : x - 11'(X_STEP);
        else if (move_right && !move_left)
          x <= (x_right > X_MAX) ? X_MAX[10:0] : x_right[10:0];
      end
    end
  end

  assign pos_x    = x;
  assign pos_y    = y;
  assign airborne = (state == RISE) || (state == FALL);

endmodule

// File: tb/tb_character_jump.sv
module tb_character_jump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        module_en = 1'b1;
  logic        jump = 1'b0;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic [37:0] vga_bus_in = '0;
  logic [37:0] vga_bus_out;
  logic [10:0] pos_x, pos_y;
  logic        airborne, landed;

  always #5 clk = ~clk;

  character_jump dut (
    .clk(clk), .rst(rst), .module_en(module_en), .jump(jump),
    .move_left(move_left), .move_right(move_right),
    .vga_bus_in(vga_bus_in), .vga_bus_out(vga_bus_out),
    .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne), .landed(landed)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model of the character
  int m_x = 384, m_y = 400, m_vel = 0, m_st = 0;
  bit m_jp = 0, m_vd = 0, m_landed = 0;
  logic [37:0] sb[$];
  bit last_landed;

  function automatic logic [37:0] pack(int hc, bit hs, bit hb, int vc, bit vs, bit vb, logic [11:0] rgb);
    logic [10:0] h11, v11;
    h11 = 11'(hc);
    v11 = 11'(vc);
    return {h11, hs, hb, v11, vs, vb, rgb};
  endfunction

  task automatic model_physics();
    int ny;
    ny = m_y + m_vel;
    case (m_st)
      0: if (m_jp || jump) begin m_vel = -16; m_st = 1; end
         else begin m_y = 400; m_vel = 0; end
      1: if (ny < 0) begin m_y = 0; m_vel = 0; m_st = 2; end
         else begin m_y = ny; m_vel = m_vel + 1; if (m_vel >= 0) m_st = 2; end
      default:
         if (ny >= 400) begin m_y = 400; m_vel = 0; m_st = 0; m_landed = 1; end
         else begin m_y = ny; m_vel = (m_vel + 1 > 16) ? 16 : m_vel + 1; end
    endcase
    if (move_left && !move_right) m_x = (m_x < 4) ? 0 : m_x - 4;
    else if (move_right && !move_left) m_x = (m_x + 4 > 768) ? 768 : m_x + 4;
  endtask

  // One clock: drive the bus, predict the registered output, check after the edge.
  task automatic cycle(int hc, bit hb, int vc, bit vs, bit vb, logic [11:0] rgb);
    logic [37:0] bus, exp;
    bit draw, tick;
    @(negedge clk);
    bus = pack(hc, hc[0], hb, vc, vs, vb, rgb);
    vga_bus_in = bus;
    m_landed = 0;
    if (rst) begin
      exp = '0;
      m_x = 384; m_y = 400; m_vel = 0; m_st = 0; m_jp = 0; m_vd = 0;
    end else begin
      draw = module_en && !hb && !vb && hc >= m_x && hc <= m_x + 31 &&
             vc >= m_y && vc <= m_y + 47;
      exp = {bus[37:12], draw ? 12'h000 : rgb};
      tick = vs && !m_vd;
      if (tick && module_en) model_physics();
      m_jp = tick ? 1'b0 : (m_jp | jump);
      m_vd = vs;
    end
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else check("bus", vga_bus_out, sb.pop_front());
    check("pos_x", pos_x, 64'(m_x));
    check("pos_y", pos_y, 64'(m_y));
    check("airborne", airborne, 64'(m_st != 0));
    check("landed", landed, 64'(m_landed));
  endtask

  task automatic frame();
    cycle(0, 1, 600, 1, 1, 12'h123);
    last_landed = landed;
    cycle(0, 1, 601, 0, 1, 12'h123);
  endtask

  task automatic run_jump_to_ground(input bool_dummy);
    for (int t = 1; t <= 34; t++) begin
      frame();
      if (t == 1)  begin check("t1_y", pos_y, 400); check("t1_air", airborne, 1); end
      if (t == 17) check("t17_y", pos_y, 264);
      if (t == 34) begin
        check("t34_y", pos_y, 400);
        check("t34_landed", last_landed, 1);
        check("t34_air", airborne, 0);
      end
    end
  endtask

  int y_frz;

  initial begin
    // reset with random bus
    rst = 1;
    for (int i = 0; i < 2; i++)
      cycle($urandom_range(0, 1000), 1'($urandom), $urandom_range(0, 1000), 0, 1'($urandom), 12'($urandom));
    check("rst_out", vga_bus_out, 0);
    rst = 0;
    for (int i = 0; i < 20; i++)
      cycle($urandom_range(0, 1000), 1'($urandom), $urandom_range(0, 1000), 0, 1'($urandom), 12'($urandom));
    check("init_x", pos_x, 384);
    check("init_y", pos_y, 400);

    // draw box
    cycle(384, 0, 400, 0, 0, 12'hFFF); check("box_in", vga_bus_out[11:0], 12'h000);
    cycle(416, 0, 400, 0, 0, 12'hFFF); check("box_right", vga_bus_out[11:0], 12'hFFF);
    cycle(415, 0, 447, 0, 0, 12'hFFF); check("box_corner", vga_bus_out[11:0], 12'h000);
    cycle(384, 0, 448, 0, 0, 12'hFFF); check("box_below", vga_bus_out[11:0], 12'hFFF);
    cycle(384, 1, 400, 0, 0, 12'hFFF); check("box_hblnk", vga_bus_out[11:0], 12'hFFF);

    // full jump from a pulse outside the tick
    frame();
    jump = 1; cycle(10, 0, 10, 0, 0, 12'h0F0); jump = 0;
    run_jump_to_ground(0);

    // jump request during the tick cycle itself, re-request at tick 5 is ignored
    jump = 1;
    for (int t = 1; t <= 34; t++) begin
      if (t == 2) jump = 0;
      if (t == 5) jump = 1;
      frame();
      if (t == 5) jump = 0;
      if (t == 1)  check("b_t1_air", airborne, 1);
      if (t == 17) check("b_t17_y", pos_y, 264);
      if (t == 34) begin check("b_t34_y", pos_y, 400); check("b_t34_landed", last_landed, 1); end
    end
    for (int t = 0; t < 5; t++) frame();
    check("no_rejump", airborne, 0);

    // horizontal clamp
    move_left = 1;
    for (int t = 0; t < 96; t++) frame();
    check("left_0", pos_x, 0);
    for (int t = 0; t < 3; t++) frame();
    check("left_hold", pos_x, 0);
    move_left = 0; move_right = 1;
    for (int t = 0; t < 200; t++) frame();
    check("right_768", pos_x, 768);
    move_right = 0;
    for (int t = 0; t < 50; t++) begin move_left = 1; frame(); end
    move_right = 1;
    for (int t = 0; t < 5; t++) frame();
    check("both_x", pos_x, 568);
    move_left = 0; move_right = 0;

    // freeze during RISE
    jump = 1; frame(); jump = 0;
    for (int t = 0; t < 4; t++) frame();
    y_frz = pos_y;
    module_en = 0;
    for (int t = 0; t < 10; t++) frame();
    check("frz_y", pos_y, 64'(y_frz));
    cycle(570, 0, y_frz + 1, 0, 0, 12'hABC); check("frz_pass", vga_bus_out[11:0], 12'hABC);
    module_en = 1;
    for (int t = 0; t < 40; t++) frame();
    check("resume_ground", pos_y, 400);

    // reset mid-air
    jump = 1; frame(); jump = 0;
    for (int t = 0; t < 8; t++) frame();
    check("mid_air", airborne, 1);
    rst = 1; cycle(0, 0, 0, 0, 0, 12'h000); rst = 0;
    check("rst_y", pos_y, 400);
    check("rst_air", airborne, 0);
    check("rst_landed", landed, 0);
    cycle(0, 0, 0, 0, 0, 12'h000);
    check("rst_landed2", landed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/character_jump.md
# character_jump

Parametrised player-character stage for the SkyHop VGA pipeline. It draws a solid rectangular character of configurable size and colour over the incoming pixel stream and owns the character's position. A once-per-frame update applies horizontal stepping and a jump/gravity state machine. It sits in the VGA bus chain after the background/platform stages and adds one register stage of latency.

## Interface
- CHAR_W, 32: character width in pixels
- CHAR_H, 48: character height in pixels
- CHAR_COLOR, 12'h000: fill colour
- SCREEN_W, 800: visible width; the x clamp bound
- X_INIT, 384: reset x of the left edge
- GROUND_Y, 400: resting y of the top edge
- JUMP_V, 16: initial upward speed, px/frame, range 1..127
- GRAVITY, 1: speed increment per frame
- VMAX, 16: maximum fall speed
- X_STEP, 4: horizontal step per frame
---
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- module_en  in  1  drawing and physics enable
- jump  in  1  jump request, level or pulse
- move_left  in  1  step left at next frame tick
- move_right  in  1  step right at next frame tick
- vga_bus_in  in  VGA_BUS_SIZE  fields: hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk, rgb[11:0]
- vga_bus_out  out  VGA_BUS_SIZE  same fields, registered
- pos_x  out  11  current left edge
- pos_y  out  11  current top edge
- airborne  out  1  high in RISE or FALL
- landed  out  1  one-cycle pulse on touchdown

## Operation
- **Frame tick:** tick = vsync_in & ~vsync_d, where vsync_d is vsync_in delayed one cycle. The tick always falls inside vblank, so position changes never tear a frame.
- **Jump request latch:** jump_pend is set by jump=1 on any cycle. It is cleared on every tick, whether the jump is accepted or not.
- **Velocity:** vel is signed 8-bit. A next-y candidate ny = y + vel is computed in signed 12-bit.
- **States (register at tick only, and only when module_en=1):**
  - IDLE: if jump_pend → vel=-JUMP_V, go to RISE; y is unchanged this tick. Otherwise y=GROUND_Y, vel=0.
  - RISE:
    - if ny<0 → y=0, vel=0, go to FALL (ceiling clamp);
    - else y=ny, vel=vel+GRAVITY; if the new vel≥0 → go to FALL.
  - FALL:
    - if ny≥GROUND_Y → y=GROUND_Y, vel=0, go to IDLE, landed=1 for that cycle;
    - else y=ny, vel=min(vel+GRAVITY, VMAX).
- **Horizontal (every tick, any state, module_en=1):**
  - left only → x=max(x-X_STEP, 0);
  - right only → x=min(x+X_STEP, SCREEN_W-CHAR_W);
  - both or neither → x unchanged.
  - Subtraction is evaluated without wrap: x<X_STEP clamps to 0.
- **Drawing:** rgb_out_nxt=CHAR_COLOR when all of the following hold; otherwise rgb_in:
  - module_en=1, hblnk_in=0, vblnk_in=0;
  - x ≤ hcount_in ≤ x+CHAR_W-1;
  - y ≤ vcount_in ≤ y+CHAR_H-1.
- **module_en=0:** rgb passes through, x/y/vel/state are frozen, ticks are ignored, and jump_pend is still cleared on each tick.
- **Reset:**
  - all vga_bus_out fields 0;
  - x=X_INIT, y=GROUND_Y, vel=0, state IDLE;
  - jump_pend=0, vsync_d=0, landed=0.

## Timing
- vga_bus_out = vga_bus_in delayed exactly 1 clk; all non-rgb fields pass through unchanged.
- x, y and state update on the clock edge of the tick cycle. pos_x/pos_y show the new values on the following cycle.
- Drawing uses the current x/y registers.
- landed is asserted during the cycle after the tick edge and only for that cycle. airborne is combinational from state.
- jump asserted on the tick cycle itself is accepted at that tick.
- jump asserted in RISE/FALL is discarded at the next tick; jumps are not buffered across a landing.
- rst mid-jump returns the character to the ground immediately, with no landed pulse.

## Test plan
- **Reset/pass-through:** rst=1 for 2 cycles, then drive bus random → all outputs 0 during reset; afterwards vga_bus_out equals vga_bus_in of the previous cycle except inside the box; pos_x=384, pos_y=400.
- **Draw box:**
  - hcount=384, vcount=400, rgb_in=12'hFFF → rgb_out=12'h000;
  - hcount=416 (x+CHAR_W) → 12'hFFF;
  - same box pixel with hblnk=1 → 12'hFFF.
- **Full jump:** jump pulse, then ticks:
  - tick1 → y=400, state RISE (vel=-16);
  - tick17 → y=264, state FALL;
  - tick34 → y=400, landed pulse, airborne=0.
- **Horizontal clamp:**
  - from x=384: 96 ticks with move_left → x=0, and further ticks keep 0;
  - move_right ticks → saturate at 768;
  - both pressed → x unchanged.
- **Jump while airborne:** jump asserted at tick 5 of a jump → trajectory identical to the single-jump case; no second jump after landing unless jump is reasserted.
- **Enable/reset mid-operation:**
  - module_en=0 for 10 ticks during RISE → y frozen and rgb passes through; re-enable → jump resumes from the frozen y/vel;
  - rst mid-air → y=400, IDLE, landed=0.
